// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg
//   Shared definitions for the SPI register bridge: FSM state encoding,
//   command-word field positions and default bank sizes.
package spi_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DATA = 2'd1,
        ST_WAIT_CS   = 2'd2,
        ST_LOAD      = 2'd3
    } state_t;

    // Command word fields
    localparam int CMD_W_BIT   = 15;
    localparam int CMD_RSVD_HI = 14;
    localparam int CMD_RSVD_LO = 8;
    localparam int CMD_ADDR_HI = 7;
    localparam int CMD_ADDR_LO = 0;

    localparam int DEF_DATA_LEN = 16;
    localparam int DEF_NUM_CTRL = 8;
    localparam int DEF_NUM_STAT = 8;

endpackage

// File: rtl/spi_reg_bridge_if.sv
// spi_reg_bridge_if
//   Bundles the SPI-slave word handshake, the raw chip select and the
//   register-bank buses of spi_reg_bridge.
//   slave  modport : the bridge (consumes RX words/status, drives TX/ctrl/err)
//   master modport : the environment (SPI slave + PVT logic side)
interface spi_reg_bridge_if
    import spi_reg_pkg::*;
#(
    parameter int DATA_LEN = DEF_DATA_LEN,
    parameter int NUM_CTRL = DEF_NUM_CTRL,
    parameter int NUM_STAT = DEF_NUM_STAT
);
    logic                         i_RX_DV;
    logic [DATA_LEN-1:0]          i_RX_Data;
    logic                         i_SPI_CS_n;
    logic [NUM_STAT*DATA_LEN-1:0] i_Status;
    logic                         o_TX_DV;
    logic [DATA_LEN-1:0]          o_TX_Data;
    logic [NUM_CTRL*DATA_LEN-1:0] o_Ctrl;
    logic [NUM_CTRL-1:0]          o_Ctrl_Wr;
    logic                         o_Err;

    modport slave (
        input  i_RX_DV, i_RX_Data, i_SPI_CS_n, i_Status,
        output o_TX_DV, o_TX_Data, o_Ctrl, o_Ctrl_Wr, o_Err
    );

    modport master (
        output i_RX_DV, i_RX_Data, i_SPI_CS_n, i_Status,
        input  o_TX_DV, o_TX_Data, o_Ctrl, o_Ctrl_Wr, o_Err
    );
endinterface

// File: rtl/spi_reg_bridge_sync_2ff.sv
// sync_2ff
//   Generic two-flop synchronizer for a single asynchronous level.
//   i_Clk : destination clock
//   i_Rst : synchronous active-high reset, loads both flops with RST_VAL
//   i_D   : asynchronous input
//   o_Q   : synchronized output
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_D,
    output logic o_Q
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_D;
            r_sync <= r_meta;
        end
    end

    assign o_Q = r_sync;
endmodule

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge
//   Decodes 16-bit words from the SPI slave into register accesses.
//   Control registers (0..NUM_CTRL-1) are read/write; status words
//   (NUM_CTRL..NUM_CTRL+NUM_STAT-1) are read-only. Read data is loaded into
//   the slave's TX register once chip select goes idle.
//   i_Clk, i_Rst : clock, synchronous active-high reset
//   bus.i_RX_DV/i_RX_Data   : received word pulse and data
//   bus.i_SPI_CS_n          : raw (asynchronous) chip select
//   bus.i_Status            : flat status words
//   bus.o_TX_DV/o_TX_Data   : TX load pulse and read data
//   bus.o_Ctrl/o_Ctrl_Wr    : control register contents and write strobes
//   bus.o_Err               : protocol-error pulse
module spi_reg_bridge
    import spi_reg_pkg::*;
#(
    parameter int                  DATA_LEN = DEF_DATA_LEN,
    parameter int                  NUM_CTRL = DEF_NUM_CTRL,
    parameter int                  NUM_STAT = DEF_NUM_STAT,
    parameter logic [DATA_LEN-1:0] CTRL_RST = '0
) (
    input logic             i_Clk,
    input logic             i_Rst,
    spi_reg_bridge_if.slave bus
);
    localparam logic [8:0] CTRL_LIM = 9'(NUM_CTRL);
    localparam logic [8:0] ADDR_LIM = 9'(NUM_CTRL + NUM_STAT);

    state_t              r_state;
    logic                r_tx_dv;
    logic [DATA_LEN-1:0] r_tx_data;
    logic [DATA_LEN-1:0] r_ctrl [NUM_CTRL];
    logic [NUM_CTRL-1:0] r_ctrl_wr;
    logic                r_err;
    logic [7:0]          r_addr;
    logic                r_cs_d;

    state_t              w_state_n;
    state_t              w_dec_state;
    logic                w_cs_s;
    logic                w_cs_rise;
    logic                w_is_wr;
    logic [7:0]          w_addr;
    logic                w_cmd_bad;
    logic [DATA_LEN-1:0] w_rd_val;
    logic                w_err_n;
    logic                w_cap_n;
    logic                w_lat_n;
    logic                w_wr_n;

    sync_2ff #(.RST_VAL(1'b1)) u_cs_sync (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .i_D   (bus.i_SPI_CS_n),
        .o_Q   (w_cs_s)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Rst) r_cs_d <= 1'b1;
        else       r_cs_d <= w_cs_s;
    end

    assign w_cs_rise = w_cs_s & ~r_cs_d;

    // Command decode of the current RX word
    assign w_is_wr   = bus.i_RX_Data[CMD_W_BIT];
    assign w_addr    = bus.i_RX_Data[CMD_ADDR_HI:CMD_ADDR_LO];
    assign w_cmd_bad = (|bus.i_RX_Data[CMD_RSVD_HI:CMD_RSVD_LO])
                     || ({1'b0, w_addr} >= ADDR_LIM)
                     || (w_is_wr && ({1'b0, w_addr} >= CTRL_LIM));
    assign w_dec_state = w_cmd_bad ? ST_IDLE : (w_is_wr ? ST_WAIT_DATA : ST_WAIT_CS);

    // Read mux: status words are sampled in the same cycle as the command
    always_comb begin
        w_rd_val = '0;
        for (int k = 0; k < NUM_CTRL; k++)
            if (w_addr == 8'(k)) w_rd_val = r_ctrl[k];
        for (int k = 0; k < NUM_STAT; k++)
            if (w_addr == 8'(NUM_CTRL + k)) w_rd_val = bus.i_Status[k*DATA_LEN +: DATA_LEN];
    end

    always_comb begin
        w_state_n = r_state;
        w_err_n   = 1'b0;
        w_cap_n   = 1'b0;
        w_lat_n   = 1'b0;
        w_wr_n    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_RX_DV) begin
                    w_state_n = w_dec_state;
                    w_err_n   = w_cmd_bad;
                    w_lat_n   = !w_cmd_bad && w_is_wr;
                    w_cap_n   = !w_cmd_bad && !w_is_wr;
                end
            end
            ST_WAIT_DATA: begin
                // A data word arriving together with the CS rise still completes
                if (bus.i_RX_DV) begin
                    w_wr_n    = 1'b1;
                    w_state_n = ST_IDLE;
                end else if (w_cs_rise) begin
                    w_err_n   = 1'b1;
                    w_state_n = ST_IDLE;
                end
            end
            ST_WAIT_CS: begin
                // Extra word in the read frame: flag it, drop the read, and
                // treat the new word as a fresh command
                if (bus.i_RX_DV) begin
                    w_state_n = w_dec_state;
                    w_err_n   = 1'b1;
                    w_lat_n   = !w_cmd_bad && w_is_wr;
                    w_cap_n   = !w_cmd_bad && !w_is_wr;
                end else if (w_cs_s) begin
                    w_state_n = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_state_n = ST_IDLE;
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state   <= ST_IDLE;
            r_tx_dv   <= 1'b0;
            r_tx_data <= '0;
            r_ctrl_wr <= '0;
            r_err     <= 1'b0;
            r_addr    <= '0;
            for (int k = 0; k < NUM_CTRL; k++) r_ctrl[k] <= CTRL_RST;
        end else begin
            r_state <= w_state_n;
            // TX_DV is high exactly while the FSM sits in LOAD
            r_tx_dv <= (w_state_n == ST_LOAD);
            r_err   <= w_err_n;
            if (w_cap_n) r_tx_data <= w_rd_val;
            if (w_lat_n) r_addr    <= w_addr;
            for (int k = 0; k < NUM_CTRL; k++) begin
                r_ctrl_wr[k] <= w_wr_n && (r_addr == 8'(k));
                if (w_wr_n && (r_addr == 8'(k))) r_ctrl[k] <= bus.i_RX_Data;
            end
        end
    end

    assign bus.o_TX_DV   = r_tx_dv;
    assign bus.o_TX_Data = r_tx_data;
    assign bus.o_Ctrl_Wr = r_ctrl_wr;
    assign bus.o_Err     = r_err;

    genvar g;
    generate
        for (g = 0; g < NUM_CTRL; g++) begin : g_ctrl
            assign bus.o_Ctrl[g*DATA_LEN +: DATA_LEN] = r_ctrl[g];
        end
    endgenerate
endmodule
